sha256_msg_ctrl: RTL and testbench
==================================

Name: sha256_msg_ctrl

Overview:
Message-level sequencer in front of sha256_core. It accepts a message as a stream of 32-bit big-endian words and buffers one 512-bit block at a time. It applies FIPS 180-4 padding and the 64-bit bit-length field, and drives the core's init/next/mode/block inputs. It returns one 256-bit digest per message over a valid/ready handshake.

Parameters:
LEN_W, 64, width of the internal message bit-length counter (range 16..64). The count is zero-extended into the 64-bit length field and wraps modulo 2^LEN_W.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-high reset. The core's reset_n is driven from the inverted reset at the top level.
mode  in  1  1 = SHA-256, 0 = SHA-224. Sampled on the first accepted word of a message.
s_data  in  32  message word; byte 0 sits in [31:24].
s_valid  in  1  s_data, s_last and s_bytes are valid.
s_last  in  1  this is the final word of the message.
s_bytes  in  3  number of valid bytes in the last word (0..4), left-aligned. Ignored when s_last=0. A value of 0 carries no data.
s_ready  out  1  word accepted when s_valid && s_ready.
core_init  out  1  one-cycle start pulse for the first block.
core_next  out  1  one-cycle start pulse for each subsequent block.
core_mode  out  1  latched mode for the current message.
core_block  out  512  block; word 0 is in [511:480].
core_ready  in  1  core idle.
core_digest  in  256  core digest.
core_digest_valid  in  1  core digest valid.
m_digest  out  256  final digest. SHA-224 users take [255:32].
m_valid  out  1  m_digest valid.
m_ready  in  1  consumer accepts the digest.

Behaviour:
- Reset values: s_ready=0, core_init=0, core_next=0, core_mode=0, core_block=0, m_digest=0, m_valid=0. Internal state: word index 0, byte count 0, first-block flag 1, state IDLE.
- States: IDLE, COLLECT, PAD, ISSUE, WAIT, PADBLK, OUT.
- IDLE: s_ready=1. The first accepted word latches mode into core_mode, then the word is handled as in COLLECT.
- COLLECT: s_ready=1. An accepted word is written to buffer word idx and idx increments.
  - Non-last word: byte count += 4. If idx reaches 16, go to ISSUE with final=0.
  - Last word: byte count += s_bytes, then go to PAD. s_ready is 0 from then until the message's digest has been handed off.
- PAD (one cycle):
  - Zero the unused bytes of the last word.
  - Place 0x80 immediately after the final data byte. If s_bytes=4 this is the next word; if that word is index 16, the 0x80 starts an extra block.
  - Zero all words after the 0x80.
  - If the 0x80 lands in word 13 or earlier: words 14..15 = {byte count, 3'b000} zero-extended to 64 bits; final=1.
  - Otherwise: final=0 and the extra-block flag is set.
- ISSUE: hold core_block stable. On the first cycle with core_ready=1, pulse core_init if the first-block flag is set, else core_next, for exactly one cycle. Clear the first-block flag, then go to WAIT. Never assert init and next together.
- WAIT: hold core_block until core_ready && core_digest_valid. Then:
  - If final: capture m_digest = core_digest and go to OUT.
  - Else if extra-block flag: go to PADBLK.
  - Else: go to COLLECT with idx=0.
- PADBLK: the block is zero except word 0 = 32'h80000000 if the 0x80 was deferred. Words 14..15 carry the length. final=1, then go to ISSUE.
- OUT: m_valid=1 with m_digest held until m_ready. The cycle after m_valid && m_ready: m_valid=0, go to IDLE, first-block flag=1, counts cleared.
- Empty message (s_last with s_bytes=0 as the first word): single block, 80000000 followed by zeros, length 0.
- Latency:
  - A full block is issued 1 cycle after its 16th word is accepted.
  - A final block is issued 2 cycles after the last word is accepted (PAD, then ISSUE).
  - A digest reaches m_valid 1 cycle after core_digest_valid is seen.
- Reset mid-message: everything returns to reset values immediately. Partial data and length are discarded, and no core pulse is issued.

Test Plan:
- "abc": one word 61626380, s_last, s_bytes=3, mode=1 -> one core_init and no core_next. m_digest = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Empty message: s_last, s_bytes=0, mode=1 -> m_digest = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- "abc" with mode=0 -> m_digest[255:32] = 23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7.
- 56-byte "abcdbcdecdefdefg...nopq" (14 words, last with s_bytes=4) -> PADBLK path, init then next. m_digest = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- 64-byte message (16 full words, last with s_bytes=4) -> two blocks. Second block word 0 = 80000000 and words 14..15 = 0000000000000200. Digest compared against the software model.
- Backpressure and reset: hold m_ready=0 for 20 cycles -> m_valid and m_digest stable, s_ready=0. Assert reset during WAIT -> all outputs 0 next edge. A following "abc" message still gives the correct digest.

Source files
------------

// File: rtl/sha256_msg_ctrl.sv
// rtl/sha256_msg_ctrl.sv - message padding and block sequencing in front of sha256_core
module sha256_msg_ctrl #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mode,
    input  logic [31:0]  s_data,
    input  logic         s_valid,
    input  logic         s_last,
    input  logic [2:0]   s_bytes,
    output logic         s_ready,
    output logic         core_init,
    output logic         core_next,
    output logic         core_mode,
    output logic [511:0] core_block,
    input  logic         core_ready,
    input  logic [255:0] core_digest,
    input  logic         core_digest_valid,
    output logic [255:0] m_digest,
    output logic         m_valid,
    input  logic         m_ready
);

    // Byte counter is three bits narrower so that {bytes, 3'b000} is exactly LEN_W bits
    localparam int BW = LEN_W - 3;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        PAD,
        ISSUE,
        WAIT,
        PADBLK,
        OUT
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [4:0]       idx_q;
    logic [BW-1:0]    byte_cnt_q;
    logic [2:0]       last_bytes_q;
    logic             first_blk_q;
    logic             final_q;
    logic             extra_q;
    logic             defer_q;
    logic             s_ready_q;
    logic             s_ready_d;
    logic             m_valid_q;
    logic             m_valid_d;
    logic             accept;
    logic [2:0]       in_bytes;
    logic [LEN_W-1:0] bit_len;
    logic [63:0]      len64;
    logic [4:0]       last_idx;
    logic [4:0]       pad_idx;
    logic             pad_final;
    logic [31:0]      keep_mask;
    logic [31:0]      tail_mark;
    logic [511:0]     pad_blk;

    assign s_ready  = s_ready_q;
    assign m_valid  = m_valid_q;
    assign accept   = s_valid && s_ready_q;
    // Out-of-range byte counts are treated as a full word
    assign in_bytes = (s_bytes > 3'd4) ? 3'd4 : s_bytes;
    assign bit_len  = {byte_cnt_q, 3'b000};

    // Zero-extend the wrapped bit length into the 64-bit length field
    always_comb begin
        len64              = '0;
        len64[LEN_W-1:0]   = bit_len;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, COLLECT: begin
                if (accept) begin
                    if (s_last) begin
                        state_d = PAD;
                    end else if (idx_q == 5'd15) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            PAD:    state_d = ISSUE;
            ISSUE:  if (core_ready) state_d = WAIT;
            WAIT: begin
                if (core_ready && core_digest_valid) begin
                    if (final_q) begin
                        state_d = OUT;
                    end else if (extra_q) begin
                        state_d = PADBLK;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            PADBLK: state_d = ISSUE;
            OUT:    if (m_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: core pulses are combinational from ISSUE, handshake flags are registered from next state
    always_comb begin
        core_init = 1'b0;
        core_next = 1'b0;
        s_ready_d = (state_d == IDLE) || (state_d == COLLECT);
        m_valid_d = (state_d == OUT);
        if ((state_q == ISSUE) && core_ready) begin
            core_init = first_blk_q;
            core_next = !first_blk_q;
        end
    end

    // Byte mask for the final word and the 0x80 marker position inside it
    always_comb begin
        keep_mask = 32'hffff_ffff;
        tail_mark = 32'h0000_0000;
        case (last_bytes_q)
            3'd0: begin keep_mask = 32'h0000_0000; tail_mark = 32'h8000_0000; end
            3'd1: begin keep_mask = 32'hff00_0000; tail_mark = 32'h0080_0000; end
            3'd2: begin keep_mask = 32'hffff_0000; tail_mark = 32'h0000_8000; end
            3'd3: begin keep_mask = 32'hffff_ff00; tail_mark = 32'h0000_0080; end
            default: begin keep_mask = 32'hffff_ffff; tail_mark = 32'h0000_0000; end
        endcase
    end

    // Padded version of the buffered block; a full last word pushes the marker into the next word
    always_comb begin
        pad_blk   = core_block;
        last_idx  = idx_q - 5'd1;
        pad_idx   = (last_bytes_q == 3'd4) ? idx_q : last_idx;
        pad_final = (pad_idx <= 5'd13);
        for (int w = 0; w < 16; w++) begin
            if (5'(w) == last_idx) begin
                pad_blk[(15 - w) * 32 +: 32] = (core_block[(15 - w) * 32 +: 32] & keep_mask) | tail_mark;
            end else if (5'(w) > last_idx) begin
                pad_blk[(15 - w) * 32 +: 32] = (5'(w) == pad_idx) ? 32'h8000_0000 : 32'h0000_0000;
            end
        end
        if (pad_final) begin
            pad_blk[63:0] = len64;
        end
    end

    // Datapath: block buffer, counters, message flags and digest capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_ready_q    <= 1'b0;
            m_valid_q    <= 1'b0;
            core_mode    <= 1'b0;
            core_block   <= '0;
            m_digest     <= '0;
            idx_q        <= '0;
            byte_cnt_q   <= '0;
            last_bytes_q <= '0;
            first_blk_q  <= 1'b1;
            final_q      <= 1'b0;
            extra_q      <= 1'b0;
            defer_q      <= 1'b0;
        end else begin
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            case (state_q)
                IDLE, COLLECT: begin
                    if (accept) begin
                        if (state_q == IDLE) begin
                            core_mode <= mode;
                        end
                        core_block[(15 - idx_q[3:0]) * 32 +: 32] <= s_data;
                        idx_q <= idx_q + 5'd1;
                        if (s_last) begin
                            byte_cnt_q   <= byte_cnt_q + BW'(in_bytes);
                            last_bytes_q <= in_bytes;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + BW'(4);
                        end
                    end
                end
                PAD: begin
                    core_block <= pad_blk;
                    final_q    <= pad_final;
                    extra_q    <= !pad_final;
                    defer_q    <= (pad_idx == 5'd16);
                end
                ISSUE: begin
                    if (core_ready) begin
                        first_blk_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (core_ready && core_digest_valid) begin
                        if (final_q) begin
                            m_digest <= core_digest;
                        end else if (!extra_q) begin
                            idx_q <= '0;
                        end
                    end
                end
                PADBLK: begin
                    core_block <= {(defer_q ? 32'h8000_0000 : 32'h0000_0000), 416'h0, len64};
                    final_q    <= 1'b1;
                    extra_q    <= 1'b0;
                end
                OUT: begin
                    if (m_ready) begin
                        first_blk_q <= 1'b1;
                        idx_q       <= '0;
                        byte_cnt_q  <= '0;
                        final_q     <= 1'b0;
                        extra_q     <= 1'b0;
                        defer_q     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// tb/tb_sha256_msg_ctrl.sv - directed bench for sha256_msg_ctrl with a behavioural sha256_core
module tb_sha256_msg_ctrl;

    localparam int CORE_LAT = 6;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] IV224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [223:0] D_ABC224 = 224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7;
    localparam logic [255:0] D_448   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mode = 1'b0;
    logic [31:0]  s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_last = 1'b0;
    logic [2:0]   s_bytes = '0;
    logic         s_ready;
    logic         core_init;
    logic         core_next;
    logic         core_mode;
    logic [511:0] core_block;
    logic         core_ready;
    logic [255:0] core_digest;
    logic         core_digest_valid;
    logic [255:0] m_digest;
    logic         m_valid;
    logic         m_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int n_init  = 0;
    int n_next  = 0;
    int n_both  = 0;
    logic [511:0] init_blk;
    logic [511:0] next_blk;
    logic [7:0]   msg_b [0:127];

    logic [255:0] mdl_h;
    logic         mdl_ready;
    logic         mdl_dv;
    int           mdl_cnt;

    sha256_msg_ctrl dut (
        .clk               (clk),
        .reset             (rst),
        .mode              (mode),
        .s_data            (s_data),
        .s_valid           (s_valid),
        .s_last            (s_last),
        .s_bytes           (s_bytes),
        .s_ready           (s_ready),
        .core_init         (core_init),
        .core_next         (core_next),
        .core_mode         (core_mode),
        .core_block        (core_block),
        .core_ready        (core_ready),
        .core_digest       (core_digest),
        .core_digest_valid (core_digest_valid),
        .m_digest          (m_digest),
        .m_valid           (m_valid),
        .m_ready           (m_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [0:63];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32 * t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
                e + hin[127:96],  f + hin[95:64],   g + hin[63:32],   h + hin[31:0]};
    endfunction

    function automatic logic [255:0] sw_digest(input int nbytes, input logic md);
        logic [7:0]   p [0:127];
        logic [511:0] blk;
        logic [255:0] h;
        logic [63:0]  bl;
        int           nblk;
        nblk = (nbytes + 8) / 64 + 1;
        for (int i = 0; i < 128; i++) begin
            if (i < nbytes) p[i] = msg_b[i];
            else p[i] = 8'h00;
        end
        p[nbytes] = 8'h80;
        bl = 64'(nbytes) << 3;
        for (int k = 0; k < 8; k++) p[nblk * 64 - 8 + k] = bl[63 - 8 * k -: 8];
        h = md ? IV256 : IV224;
        for (int bi = 0; bi < nblk; bi++) begin
            for (int j = 0; j < 64; j++) blk[511 - 8 * j -: 8] = p[bi * 64 + j];
            h = compress(h, blk);
        end
        return h;
    endfunction

    // Behavioural sha256_core: busy for CORE_LAT cycles after each start pulse
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_ready <= 1'b1;
            mdl_dv    <= 1'b0;
            mdl_cnt   <= 0;
            mdl_h     <= '0;
        end else if (core_init || core_next) begin
            mdl_h     <= compress(core_init ? (core_mode ? IV256 : IV224) : mdl_h, core_block);
            mdl_ready <= 1'b0;
            mdl_dv    <= 1'b0;
            mdl_cnt   <= CORE_LAT;
        end else if (mdl_cnt > 0) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1) begin
                mdl_ready <= 1'b1;
                mdl_dv    <= 1'b1;
            end
        end
    end
    assign core_ready        = mdl_ready;
    assign core_digest_valid = mdl_dv;
    assign core_digest       = mdl_h;

    // Pulse counters and block capture
    always @(posedge clk) begin
        if (!rst) begin
            if (core_init) begin n_init <= n_init + 1; init_blk <= core_block; end
            if (core_next) begin n_next <= n_next + 1; next_blk <= core_block; end
            if (core_init && core_next) n_both <= n_both + 1;
        end
    end

    task automatic load_str(input string s);
        for (int i = 0; i < 128; i++) begin
            if (i < s.len()) msg_b[i] = s[i];
            else msg_b[i] = 8'hA5;
        end
    endtask

    task automatic load_pattern(input int n);
        for (int i = 0; i < 128; i++) begin
            if (i < n) msg_b[i] = 8'(i * 37 + 11);
            else msg_b[i] = 8'hA5;
        end
    endtask

    task automatic send_msg(input int nbytes, input logic md);
        int nw;
        int lb;
        int c;
        nw = (nbytes == 0) ? 1 : (nbytes + 3) / 4;
        mode = md;
        for (int i = 0; i < nw; i++) begin
            lb = (i == nw - 1) ? nbytes - 4 * i : 4;
            s_data  = {msg_b[4*i], msg_b[4*i+1], msg_b[4*i+2], msg_b[4*i+3]};
            s_valid = 1'b1;
            s_last  = (i == nw - 1);
            s_bytes = (i == nw - 1) ? 3'(lb) : 3'd7;
            c = 0;
            while (!s_ready && c < 200) begin @(negedge clk); c++; end
            if (c >= 200) begin
                n_tests++; n_fail++;
                $display("FAIL send_timeout word %0d s_ready stayed 0, required 1", i);
            end
            @(posedge clk);
            @(negedge clk);
            mode = ~md;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 32'hdead_beef;
    endtask

    task automatic wait_valid();
        int c = 0;
        while (!m_valid && c < 400) begin @(negedge clk); c++; end
        if (!m_valid) begin
            n_tests++; n_fail++;
            $display("FAIL digest_timeout m_valid=0 after %0d cycles, required 1", c);
        end
    endtask

    task automatic take_digest();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready got %b exp 0", s_ready); end
        n_tests++; if ({core_init, core_next, core_mode} !== 3'b000) begin n_fail++; $display("FAIL rst_core_ctl got %b exp 000", {core_init, core_next, core_mode}); end
        n_tests++; if (core_block !== 512'h0) begin n_fail++; $display("FAIL rst_core_block got %h exp 0", core_block); end
        n_tests++; if (m_valid !== 1'b0 || m_digest !== 256'h0) begin n_fail++; $display("FAIL rst_m got %b %h exp 0 0", m_valid, m_digest); end
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL idle_s_ready got %b exp 1", s_ready); end
    endtask

    task automatic test_abc();
        int i0, n0;
        load_str("abc");
        i0 = n_init; n0 = n_next;
        send_msg(3, 1'b1);
        n_tests++; if (core_init !== 1'b0 || s_ready !== 1'b0) begin n_fail++; $display("FAIL abc_pad_cycle init=%b s_ready=%b exp 0 0", core_init, s_ready); end
        @(negedge clk);
        n_tests++; if (core_init !== 1'b1 || core_next !== 1'b0) begin n_fail++; $display("FAIL abc_issue_latency init=%b next=%b exp 1 0", core_init, core_next); end
        n_tests++; if (core_block !== {32'h61626380, 416'h0, 64'h18}) begin n_fail++; $display("FAIL abc_block got %h", core_block); end
        wait_valid();
        n_tests++; if (m_digest !== D_ABC) begin n_fail++; $display("FAIL abc_digest got %h exp %h", m_digest, D_ABC); end
        n_tests++; if (n_init - i0 != 1 || n_next - n0 != 0) begin n_fail++; $display("FAIL abc_pulses init=%0d next=%0d exp 1 0", n_init - i0, n_next - n0); end
        n_tests++; if (core_mode !== 1'b1) begin n_fail++; $display("FAIL abc_mode_latch got %b exp 1", core_mode); end
        take_digest();
        n_tests++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL abc_handoff m_valid=%b s_ready=%b exp 0 1", m_valid, s_ready); end
    endtask

    task automatic test_empty();
        load_str("");
        send_msg(0, 1'b1);
        @(negedge clk);
        n_tests++; if (core_block !== {32'h80000000, 480'h0}) begin n_fail++; $display("FAIL empty_block got %h", core_block); end
        wait_valid();
        n_tests++; if (m_digest !== D_EMPTY) begin n_fail++; $display("FAIL empty_digest got %h exp %h", m_digest, D_EMPTY); end
        take_digest();
    endtask

    task automatic test_abc224();
        load_str("abc");
        send_msg(3, 1'b0);
        wait_valid();
        n_tests++; if (core_mode !== 1'b0) begin n_fail++; $display("FAIL abc224_mode got %b exp 0", core_mode); end
        n_tests++; if (m_digest[255:32] !== D_ABC224) begin n_fail++; $display("FAIL abc224_digest got %h exp %h", m_digest[255:32], D_ABC224); end
        take_digest();
    endtask

    task automatic test_two_block_56();
        int i0, n0;
        load_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
        i0 = n_init; n0 = n_next;
        send_msg(56, 1'b1);
        wait_valid();
        n_tests++; if (m_digest !== D_448) begin n_fail++; $display("FAIL b56_digest got %h exp %h", m_digest, D_448); end
        n_tests++; if (n_init - i0 != 1 || n_next - n0 != 1) begin n_fail++; $display("FAIL b56_pulses init=%0d next=%0d exp 1 1", n_init - i0, n_next - n0); end
        n_tests++; if (init_blk[63:0] !== 64'h80000000_00000000) begin n_fail++; $display("FAIL b56_first_tail got %h exp 8000000000000000", init_blk[63:0]); end
        n_tests++; if (next_blk !== {448'h0, 64'h1c0}) begin n_fail++; $display("FAIL b56_padblk got %h", next_blk); end
        take_digest();
    endtask

    task automatic test_64byte();
        logic [511:0] exp_blk;
        logic [255:0] exp_d;
        load_pattern(64);
        for (int j = 0; j < 64; j++) exp_blk[511 - 8 * j -: 8] = msg_b[j];
        exp_d = sw_digest(64, 1'b1);
        send_msg(64, 1'b1);
        wait_valid();
        n_tests++; if (init_blk !== exp_blk) begin n_fail++; $display("FAIL b64_first_block got %h", init_blk); end
        n_tests++; if (next_blk[511:480] !== 32'h80000000) begin n_fail++; $display("FAIL b64_word0 got %h exp 80000000", next_blk[511:480]); end
        n_tests++; if (next_blk[63:0] !== 64'h200 || next_blk[479:64] !== 416'h0) begin n_fail++; $display("FAIL b64_len got %h exp 0000000000000200", next_blk[63:0]); end
        n_tests++; if (m_digest !== exp_d) begin n_fail++; $display("FAIL b64_digest got %h exp %h", m_digest, exp_d); end
        take_digest();
    endtask

    task automatic test_multi_block();
        int i0, n0;
        logic [255:0] exp_d;
        load_pattern(100);
        exp_d = sw_digest(100, 1'b1);
        i0 = n_init; n0 = n_next;
        send_msg(100, 1'b1);
        wait_valid();
        n_tests++; if (n_init - i0 != 1 || n_next - n0 != 1) begin n_fail++; $display("FAIL b100_pulses init=%0d next=%0d exp 1 1", n_init - i0, n_next - n0); end
        n_tests++; if (next_blk[63:0] !== 64'h320) begin n_fail++; $display("FAIL b100_len got %h exp 320", next_blk[63:0]); end
        n_tests++; if (m_digest !== exp_d) begin n_fail++; $display("FAIL b100_digest got %h exp %h", m_digest, exp_d); end
        take_digest();
    endtask

    task automatic test_partial_224();
        logic [255:0] exp_d;
        load_pattern(17);
        exp_d = sw_digest(17, 1'b0);
        send_msg(17, 1'b0);
        wait_valid();
        n_tests++; if (init_blk[511-128 -: 32] !== {msg_b[16], 24'h800000}) begin n_fail++; $display("FAIL p17_last_word got %h", init_blk[511-128 -: 32]); end
        n_tests++; if (m_digest[255:32] !== exp_d[255:32]) begin n_fail++; $display("FAIL p17_digest got %h exp %h", m_digest[255:32], exp_d[255:32]); end
        take_digest();
    endtask

    task automatic test_backpressure();
        load_str("abc");
        send_msg(3, 1'b1);
        wait_valid();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_tests++;
            if (m_valid !== 1'b1 || m_digest !== D_ABC || s_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cyc %0d m_valid=%b s_ready=%b digest=%h exp 1 0 %h", i, m_valid, s_ready, m_digest, D_ABC);
            end
        end
        take_digest();
    endtask

    task automatic test_reset_wait();
        int i0, c;
        load_str("abc");
        i0 = n_init;
        send_msg(3, 1'b1);
        c = 0;
        while (n_init == i0 && c < 50) begin @(negedge clk); c++; end
        n_tests++; if (n_init == i0) begin n_fail++; $display("FAIL rw_no_init init count %0d exp %0d", n_init, i0 + 1); end
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if ({s_ready, core_init, core_next, core_mode, m_valid} !== 5'b0) begin n_fail++; $display("FAIL rw_ctl got %b exp 00000", {s_ready, core_init, core_next, core_mode, m_valid}); end
        n_tests++; if (core_block !== 512'h0 || m_digest !== 256'h0) begin n_fail++; $display("FAIL rw_data got %h %h exp 0", core_block, m_digest); end
        rst = 1'b0;
        i0 = n_init;
        repeat (10) @(negedge clk);
        n_tests++; if (n_init != i0 || m_valid !== 1'b0) begin n_fail++; $display("FAIL rw_quiet init=%0d m_valid=%b exp %0d 0", n_init, m_valid, i0); end
        load_str("abc");
        send_msg(3, 1'b1);
        wait_valid();
        n_tests++; if (m_digest !== D_ABC) begin n_fail++; $display("FAIL rw_abc_digest got %h exp %h", m_digest, D_ABC); end
        take_digest();
    endtask

    initial begin
        test_reset();
        test_abc();
        test_empty();
        test_abc224();
        test_two_block_56();
        test_64byte();
        test_multi_block();
        test_partial_224();
        test_backpressure();
        test_reset_wait();
        n_tests++; if (n_both != 0) begin n_fail++; $display("FAIL init_next_overlap count %0d exp 0", n_both); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
